// File: rtl/jts16_rom_resp.sv
// SDRAM read responder for four graphics ROM client slots. Each slot keeps a
// single-entry tag cache; misses are served one at a time in round-robin order.
module jts16_rom_resp #(
    parameter int          AW           = 18,
    parameter int          DW           = 32,
    parameter logic [21:0] SLOT0_OFFSET = 22'h0,
    parameter logic [21:0] SLOT1_OFFSET = 22'h0,
    parameter logic [21:0] SLOT2_OFFSET = 22'h0,
    parameter logic [21:0] SLOT3_OFFSET = 22'h0
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          slot0_cs,
    input  logic [AW-1:0] slot0_addr,
    output logic          slot0_ok,
    output logic [DW-1:0] slot0_dout,
    input  logic          slot1_cs,
    input  logic [AW-1:0] slot1_addr,
    output logic          slot1_ok,
    output logic [DW-1:0] slot1_dout,
    input  logic          slot2_cs,
    input  logic [AW-1:0] slot2_addr,
    output logic          slot2_ok,
    output logic [DW-1:0] slot2_dout,
    input  logic          slot3_cs,
    input  logic [AW-1:0] slot3_addr,
    output logic          slot3_ok,
    output logic [DW-1:0] slot3_dout,
    output logic          sdram_req,
    output logic [21:0]   sdram_addr,
    input  logic          sdram_ack,
    input  logic          sdram_rdy,
    input  logic [DW-1:0] sdram_din
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    logic [3:0]    cs, hit, need, ok;
    logic [AW-1:0] addr   [4];
    logic [21:0]   offset [4];

    state_t        state_q, state_d;
    logic [AW-1:0] tag_q   [4];
    logic [AW-1:0] tag_d   [4];
    logic [DW-1:0] data_q  [4];
    logic [DW-1:0] data_d  [4];
    logic [3:0]    valid_q, valid_d;
    logic [1:0]    rr_q, rr_d;
    logic [1:0]    sel_q, sel_d;
    logic [AW-1:0] ptag_q, ptag_d;
    logic          req_q, req_d;
    logic [21:0]   saddr_q, saddr_d;

    logic          pick_vld;
    logic [1:0]    pick;
    logic          fill;

    assign cs = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
    assign addr[0] = slot0_addr;
    assign addr[1] = slot1_addr;
    assign addr[2] = slot2_addr;
    assign addr[3] = slot3_addr;
    assign offset[0] = SLOT0_OFFSET;
    assign offset[1] = SLOT1_OFFSET;
    assign offset[2] = SLOT2_OFFSET;
    assign offset[3] = SLOT3_OFFSET;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign hit[gi]  = valid_q[gi] && (addr[gi] == tag_q[gi]);
            assign need[gi] = cs[gi] && !hit[gi];
        end
    endgenerate

    // ok is combinational so it falls in the very cycle the address moves
    assign ok = cs & hit;
    assign slot0_ok = ok[0];
    assign slot1_ok = ok[1];
    assign slot2_ok = ok[2];
    assign slot3_ok = ok[3];
    assign slot0_dout = data_q[0];
    assign slot1_dout = data_q[1];
    assign slot2_dout = data_q[2];
    assign slot3_dout = data_q[3];
    assign sdram_req  = req_q;
    assign sdram_addr = saddr_q;

    // Scan downwards so the slot closest to rr_q is the one that sticks
    always_comb begin
        logic [1:0] idx;
        pick_vld = 1'b0;
        pick     = rr_q;
        idx      = rr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_q + 2'(k);
            if (need[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        ptag_d  = ptag_q;
        req_d   = req_q;
        saddr_d = saddr_q;
        fill    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    sel_d   = pick;
                    ptag_d  = addr[pick];
                    saddr_d = 22'(addr[pick]) + offset[pick];
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    fill    = sdram_rdy;
                    state_d = sdram_rdy ? IDLE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (sdram_rdy) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Fill uses the tag latched at issue time, not the slot's live address
        if (fill) begin
            data_d[sel_q]  = sdram_din;
            tag_d[sel_q]   = ptag_q;
            valid_d[sel_q] = 1'b1;
            rr_d           = sel_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < 4; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            rr_q    <= 2'd0;
            sel_q   <= 2'd0;
            ptag_q  <= '0;
            req_q   <= 1'b0;
            saddr_q <= 22'd0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            ptag_q  <= ptag_d;
            req_q   <= req_d;
            saddr_q <= saddr_d;
        end
    end
endmodule

// File: tb/tb_jts16_rom_resp.sv
// Directed bench for jts16_rom_resp: table of single-slot fills plus
// hand-written sequences for arbitration, in-flight changes and reset abort.
module tb_jts16_rom_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_cs = 0, s1_cs = 0, s2_cs = 0, s3_cs = 0;
    logic [17:0] s0_addr = 0, s1_addr = 0, s2_addr = 0, s3_addr = 0;
    logic        s0_ok, s1_ok, s2_ok, s3_ok;
    logic [31:0] s0_dout, s1_dout, s2_dout, s3_dout;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack = 0, sdram_rdy = 0;
    logic [31:0] sdram_din = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jts16_rom_resp #(
        .AW(18), .DW(32),
        .SLOT0_OFFSET(22'h040000), .SLOT1_OFFSET(22'h002000),
        .SLOT2_OFFSET(22'h000100), .SLOT3_OFFSET(22'h3FFFFF)
    ) dut (
        .rst(rst), .clk(clk),
        .slot0_cs(s0_cs), .slot0_addr(s0_addr), .slot0_ok(s0_ok), .slot0_dout(s0_dout),
        .slot1_cs(s1_cs), .slot1_addr(s1_addr), .slot1_ok(s1_ok), .slot1_dout(s1_dout),
        .slot2_cs(s2_cs), .slot2_addr(s2_addr), .slot2_ok(s2_ok), .slot2_dout(s2_dout),
        .slot3_cs(s3_cs), .slot3_addr(s3_addr), .slot3_ok(s3_ok), .slot3_dout(s3_dout),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
    );

    typedef struct {
        int          slot;
        logic [17:0] addr;
        logic [31:0] din;
        logic [21:0] exp_addr;
    } vec_t;
    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic set_slot(input int s, input logic cs, input logic [17:0] a);
        case (s)
            0: begin s0_cs = cs; s0_addr = a; end
            1: begin s1_cs = cs; s1_addr = a; end
            2: begin s2_cs = cs; s2_addr = a; end
            default: begin s3_cs = cs; s3_addr = a; end
        endcase
    endtask

    function automatic logic get_ok(input int s);
        case (s)
            0: return s0_ok;
            1: return s1_ok;
            2: return s2_ok;
            default: return s3_ok;
        endcase
    endfunction

    function automatic logic [31:0] get_dout(input int s);
        case (s)
            0: return s0_dout;
            1: return s1_dout;
            2: return s2_dout;
            default: return s3_dout;
        endcase
    endfunction

    task automatic wait_req(output int n);
        n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        if (!sdram_req) begin
            failures++;
            checks++;
            $display("FAIL req_timeout: got req=0 expected req=1 within 20 cycles");
        end
    endtask

    // Ack (optionally with rdy in the same cycle), then deliver data
    task automatic serve(input logic [31:0] d, input bit same);
        sdram_ack = 1'b1;
        if (same) begin
            sdram_rdy = 1'b1;
            sdram_din = d;
        end
        tick();
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        check("req_drop_after_ack", sdram_req, 0);
        if (!same) begin
            sdram_rdy = 1'b1;
            sdram_din = d;
            tick();
            sdram_rdy = 1'b0;
        end
    endtask

    initial begin
        int n, req_seen, ok_drops;
        logic [21:0] seq_addr [6];
        vecs[0] = '{0, 18'h00123, 32'hDEADBEEF, 22'h040123};
        vecs[1] = '{1, 18'h00456, 32'h11112222, 22'h002456};
        vecs[2] = '{2, 18'h3FFFF, 32'hCAFEF00D, 22'h0400FF};
        vecs[3] = '{3, 18'h00002, 32'h0BADC0DE, 22'h000001};
        seq_addr = '{22'h040100, 22'h002200, 22'h000110, 22'h0002FF, 22'h040101, 22'h000120};

        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_req", sdram_req, 0);
        check("reset_addr", sdram_addr, 0);
        check("reset_ok", {s3_ok, s2_ok, s1_ok, s0_ok}, 0);
        check("reset_dout0", s0_dout, 0);

        // Single-slot fills; previously filled slots stay selected and cached
        for (int i = 0; i < 4; i++) begin
            set_slot(vecs[i].slot, 1'b1, vecs[i].addr);
            #1;
            check("miss_ok_low", get_ok(vecs[i].slot), 0);
            tick();
            check("req_latency", sdram_req, 1);
            check("req_addr", sdram_addr, vecs[i].exp_addr);
            serve(vecs[i].din, 1'b0);
            check("fill_ok", get_ok(vecs[i].slot), 1);
            check("fill_dout", get_dout(vecs[i].slot), vecs[i].din);
        end

        req_seen = 0;
        ok_drops = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sdram_req) req_seen++;
            if (!s0_ok) ok_drops++;
        end
        check("hold_no_req", req_seen, 0);
        check("hold_ok_drops", ok_drops, 0);

        s0_addr = 18'h00124;
        #1;
        check("addr_change_ok_same_cycle", s0_ok, 0);
        tick();
        check("rereq", sdram_req, 1);
        check("rereq_addr", sdram_addr, 22'h040124);
        serve(32'h00000055, 1'b0);
        check("rereq_dout", s0_dout, 32'h55);

        // Four-way arbitration from pointer 0, with slot0 moving and slot2
        // moving while in flight
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_slot(0, 1'b1, 18'h100);
        set_slot(1, 1'b1, 18'h200);
        set_slot(2, 1'b1, 18'h010);
        set_slot(3, 1'b1, 18'h300);
        for (int i = 0; i < 6; i++) begin
            wait_req(n);
            if (i > 0) check("gap_one_idle", n, 1);
            check("rr_order_addr", sdram_addr, seq_addr[i]);
            if (i == 2) begin
                sdram_ack = 1'b1;
                tick();
                sdram_ack = 1'b0;
                s2_addr = 18'h020;
                sdram_rdy = 1'b1;
                sdram_din = 32'hA0000002;
                tick();
                sdram_rdy = 1'b0;
                check("inflight_ok_low", s2_ok, 0);
                check("inflight_dout", s2_dout, 32'hA0000002);
            end else begin
                serve(32'hA0000000 + 32'(i), 1'b0);
                if (i == 0) s0_addr = 18'h101;
            end
        end
        tick();
        check("rr_all_ok", {s3_ok, s2_ok, s1_ok, s0_ok}, 4'hF);
        check("rr_dout0", s0_dout, 32'hA0000004);
        check("rr_dout2", s2_dout, 32'hA0000005);
        check("rr_dout3", s3_dout, 32'hA0000003);

        // Reset during WAIT_DATA, then a stale rdy after release
        set_slot(0, 1'b0, 18'h0);
        set_slot(2, 1'b0, 18'h0);
        set_slot(3, 1'b0, 18'h0);
        s1_addr = 18'h777;
        wait_req(n);
        check("abort_req_addr", sdram_addr, 22'h002777);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_req_async", sdram_req, 0);
        check("abort_dout_async", s1_dout, 0);
        s1_cs = 1'b0;
        tick();
        rst = 1'b0;
        sdram_rdy = 1'b1;
        sdram_din = 32'h99999999;
        tick();
        sdram_rdy = 1'b0;
        check("stale_rdy_dout", s1_dout, 0);
        check("stale_rdy_req", sdram_req, 0);
        s1_cs = 1'b1;
        #1;
        check("stale_rdy_ok", s1_ok, 0);
        tick();
        check("post_abort_req_idle", sdram_req, 1);

        // Ack and rdy together; slot3 waits and goes after one IDLE cycle
        set_slot(3, 1'b1, 18'h00005);
        serve(32'h12345678, 1'b1);
        check("same_cycle_ok", s1_ok, 1);
        check("same_cycle_dout", s1_dout, 32'h12345678);
        wait_req(n);
        check("same_cycle_gap", n, 1);
        check("wrap_addr", sdram_addr, 22'h000004);
        serve(32'h0000ABCD, 1'b0);
        check("wrap_dout", s3_dout, 32'h0000ABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
